// File: rtl/handshake_constant_burst.sv
// Elastic constant/sequence source: each accepted control token yields BURST_LEN registered
// beats CONST_VALUE + k*STRIDE. Define HANDSHAKE_CONST_LAST_EN to add the outs_last output.
module handshake_constant_burst #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [63:0] CONST_VALUE = 64'd0,
  parameter logic [63:0] STRIDE      = 64'd0,
  parameter int unsigned BURST_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
`ifdef HANDSHAKE_CONST_LAST_EN
  output logic                  outs_last,
`endif
  input  logic                  outs_ready
);

  if (BURST_LEN < 1) begin : g_bad_burst_len
    $error("handshake_constant_burst: BURST_LEN must be at least 1");
  end

  localparam int unsigned           CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] CONST_W  = DATA_WIDTH'(CONST_VALUE);
  localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   outs_q, outs_d;
  logic                    valid_q, valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_fire;
  logic                    last;

  assign out_fire = valid_q && outs_ready;
  assign last     = (cnt_q == LAST_CNT);

  // NOTE: every variable gets a default before the case, so no path through the block can infer a latch.
  always_comb begin
    state_d    = state_q;
    outs_d     = outs_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    ctrl_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ctrl_ready = 1'b1;
        if (ctrl_valid) begin
          outs_d  = CONST_W;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_fire) begin
          if (!last) begin
            cnt_d  = cnt_q + CNT_W'(1);
            outs_d = outs_q + STRIDE_W;
          end else begin
            // Burst ends this cycle; a waiting token restarts with no bubble.
            ctrl_ready = 1'b1;
            cnt_d      = '0;
            if (ctrl_valid) begin
              outs_d = CONST_W;
            end else begin
              valid_d = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      outs_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outs       = outs_q;
  assign outs_valid = valid_q;

`ifdef HANDSHAKE_CONST_LAST_EN
  logic last_q, last_d;

  assign last_d = valid_d && (cnt_d == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign outs_last = last_q;

  a_last_implies_valid: assert property (@(posedge clk) disable iff (!rst) last_q |-> valid_q);
`endif

  // Offered data must not change or vanish while the consumer stalls.
  a_hold_under_stall: assert property (@(posedge clk) disable iff (!rst)
    (valid_q && !outs_ready) |=> (valid_q && $stable(outs_q)));

endmodule

// File: tb/tb_handshake_constant_burst.sv
// Self-checking bench for handshake_constant_burst: vector table, directed corner sequences,
// and randomized handshakes checked against a queue-of-beats reference model.
`timescale 1ns/1ps
module tb_handshake_constant_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_cv, a_cr, a_ov, a_or;
  logic [7:0] a_outs;
  logic       w_cv, w_cr, w_ov, w_or;
  logic [7:0] w_outs;
  logic       t_cv, t_cr, t_ov, t_or;
  logic [7:0] t_outs;
`ifdef HANDSHAKE_CONST_LAST_EN
  logic a_last, w_last, t_last;
`endif

  handshake_constant_burst #(.DATA_WIDTH(8), .CONST_VALUE(64'h10), .STRIDE(64'd3), .BURST_LEN(4)) u_a (
    .clk(clk), .rst(rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr), .outs(a_outs), .outs_valid(a_ov),
`ifdef HANDSHAKE_CONST_LAST_EN
    .outs_last(a_last),
`endif
    .outs_ready(a_or));

  handshake_constant_burst #(.DATA_WIDTH(8), .CONST_VALUE(64'hFE), .STRIDE(64'd1), .BURST_LEN(3)) u_w (
    .clk(clk), .rst(rst), .ctrl_valid(w_cv), .ctrl_ready(w_cr), .outs(w_outs), .outs_valid(w_ov),
`ifdef HANDSHAKE_CONST_LAST_EN
    .outs_last(w_last),
`endif
    .outs_ready(w_or));

  handshake_constant_burst #(.DATA_WIDTH(8), .CONST_VALUE(64'hA5), .STRIDE(64'd0), .BURST_LEN(1)) u_t (
    .clk(clk), .rst(rst), .ctrl_valid(t_cv), .ctrl_ready(t_cr), .outs(t_outs), .outs_valid(t_ov),
`ifdef HANDSHAKE_CONST_LAST_EN
    .outs_last(t_last),
`endif
    .outs_ready(t_or));

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       cv;
    logic       rdy;
    logic       exp_ov;
    logic [7:0] exp_outs;
    logic       exp_cr;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cv, input logic rdy, input logic ov, input logic [7:0] o,
                     input logic cr, input logic lst);
    vec_t v;
    v.cv = cv; v.rdy = rdy; v.exp_ov = ov; v.exp_outs = o; v.exp_cr = cr; v.exp_last = lst;
    vecs.push_back(v);
  endtask

  typedef struct {
    logic [7:0] val;
    logic       last;
  } beat_t;

  beat_t model_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wexp [3];
    int         cf, of;
    logic       exp_ready, exp_tv;

    rst = 1'b0;
    a_cv = 1'b0; a_or = 1'b0;
    w_cv = 1'b0; w_or = 1'b0;
    t_cv = 1'b0; t_or = 1'b0;

    // Reset held three cycles, then idle with no tokens.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset c%0d outs_valid", c), a_ov, 0);
      check($sformatf("reset c%0d outs", c), a_outs, 0);
      check($sformatf("reset c%0d ctrl_ready", c), a_cr, 1);
`ifdef HANDSHAKE_CONST_LAST_EN
      check($sformatf("reset c%0d outs_last", c), a_last, 0);
`endif
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("idle c%0d a outs_valid", c), a_ov, 0);
      check($sformatf("idle c%0d a outs", c), a_outs, 0);
      check($sformatf("idle c%0d a ctrl_ready", c), a_cr, 1);
      check($sformatf("idle c%0d w outs_valid", c), w_ov, 0);
      check($sformatf("idle c%0d t outs_valid", c), t_ov, 0);
    end

    // Burst values, then the same burst with a 5-cycle stall on beat 1.
    add(1, 1, 0, 8'h00, 1, 0);
    add(0, 1, 1, 8'h10, 0, 0);
    add(0, 1, 1, 8'h13, 0, 0);
    add(0, 1, 1, 8'h16, 0, 0);
    add(0, 1, 1, 8'h19, 1, 1);
    add(0, 1, 0, 8'h19, 1, 0);
    add(1, 1, 0, 8'h19, 1, 0);
    add(0, 1, 1, 8'h10, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 8'h13, 0, 0);
    add(0, 1, 1, 8'h13, 0, 0);
    add(0, 1, 1, 8'h16, 0, 0);
    add(0, 1, 1, 8'h19, 1, 1);
    add(0, 1, 0, 8'h19, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_cv = vecs[i].cv;
      a_or = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d outs_valid", i), a_ov, vecs[i].exp_ov);
      check($sformatf("vec%0d outs", i), a_outs, vecs[i].exp_outs);
      check($sformatf("vec%0d ctrl_ready", i), a_cr, vecs[i].exp_cr);
`ifdef HANDSHAKE_CONST_LAST_EN
      check($sformatf("vec%0d outs_last", i), a_last, vecs[i].exp_last);
`endif
      tick();
    end

    // Wrap-around across 0xFF.
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00;
    w_cv = 1'b1; w_or = 1'b1;
    #1;
    check("wrap accept ctrl_ready", w_cr, 1);
    tick();
    w_cv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("wrap beat%0d outs_valid", k), w_ov, 1);
      check($sformatf("wrap beat%0d outs", k), w_outs, wexp[k]);
      check($sformatf("wrap beat%0d ctrl_ready", k), w_cr, (k == 2) ? 1 : 0);
`ifdef HANDSHAKE_CONST_LAST_EN
      check($sformatf("wrap beat%0d outs_last", k), w_last, (k == 2) ? 1 : 0);
`endif
      tick();
    end
    check("wrap after outs_valid", w_ov, 0);

    // Back-to-back single-beat tokens.
    cf = 0; of = 0;
    t_or = 1'b1;
    for (int c = 0; c < 12; c++) begin
      t_cv = (c < 10);
      #1;
      exp_tv = (c >= 1) && (c <= 10);
      check($sformatf("thru c%0d outs_valid", c), t_ov, exp_tv);
      if (exp_tv) check($sformatf("thru c%0d outs", c), t_outs, 8'hA5);
`ifdef HANDSHAKE_CONST_LAST_EN
      check($sformatf("thru c%0d outs_last", c), t_last, exp_tv);
`endif
      if (t_cv && t_cr) cf++;
      if (t_ov && t_or) of++;
      tick();
    end
    check("thru ctrl_fire count", cf, 10);
    check("thru out_fire count", of, 10);
    check("thru fire balance", of, cf);

    // Asynchronous reset during beat 2.
    a_cv = 1'b1; a_or = 1'b1;
    tick();
    a_cv = 1'b0;
    tick();
    tick();
    #1;
    check("midrst beat2 outs", a_outs, 8'h16);
    #2 rst = 1'b0;
    #1;
    check("midrst async outs_valid", a_ov, 0);
    check("midrst async outs", a_outs, 0);
    check("midrst async ctrl_ready", a_cr, 1);
    @(negedge clk);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("midrst idle c%0d outs_valid", c), a_ov, 0);
    end
    a_cv = 1'b1;
    tick();
    a_cv = 1'b0;
    #1;
    check("midrst restart outs_valid", a_ov, 1);
    check("midrst restart outs", a_outs, 8'h10);
    for (int c = 0; c < 5; c++) tick();
    check("midrst drained outs_valid", a_ov, 0);

    // Randomized handshakes against the beat-queue model.
    for (int c = 0; c < 400; c++) begin
      a_cv = ($urandom_range(0, 2) != 0);
      a_or = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (model_q.size() == 0) || (a_or && model_q.size() == 1);
      check($sformatf("rnd c%0d ctrl_ready", c), a_cr, exp_ready);
      check($sformatf("rnd c%0d outs_valid", c), a_ov, model_q.size() != 0);
      if (model_q.size() != 0) begin
        check($sformatf("rnd c%0d outs", c), a_outs, model_q[0].val);
`ifdef HANDSHAKE_CONST_LAST_EN
        check($sformatf("rnd c%0d outs_last", c), a_last, model_q[0].last);
`endif
        if (a_or) void'(model_q.pop_front());
      end
      if (a_cv && exp_ready) begin
        for (int k = 0; k < 4; k++) begin
          beat_t b;
          b.val  = 8'(16 + k * 3);
          b.last = (k == 3);
          model_q.push_back(b);
        end
      end
      tick();
    end
    a_cv = 1'b0; a_or = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    check("rnd drained outs_valid", a_ov, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_constant_burst.md
Name: handshake_constant_burst

Overview:
- Elastic constant/sequence source for the dataflow handshake library.
- Each accepted control token produces a burst of BURST_LEN output tokens carrying CONST_VALUE, CONST_VALUE+STRIDE, CONST_VALUE+2*STRIDE, and so on.
- Output is registered, which breaks the combinational valid path from ctrl to outs.
- With BURST_LEN=1 and STRIDE=0 it is a registered drop-in for the plain constant unit.

Parameters:
- DATA_WIDTH, 32, width of outs.
- CONST_VALUE, 0, first value of every burst; truncated to DATA_WIDTH.
- STRIDE, 0, increment added per beat; truncated to DATA_WIDTH, two's-complement wrap.
- BURST_LEN, 1, output tokens per control token; legal range is 1 and above. Elaboration fails on 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- ctrl_valid  input  1  control token offered.
- ctrl_ready  output  1  control token accepted when ctrl_valid && ctrl_ready.
- outs  output  DATA_WIDTH  registered output data.
- outs_valid  output  1  registered output valid.
- outs_ready  input  1  downstream ready.
- outs_last  output  1  final beat of burst; present only with HANDSHAKE_CONST_LAST_EN.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert at the block boundary):
  - state=IDLE, outs=0, outs_valid=0, beat counter=0, outs_last=0.
  - ctrl_ready is 1 while in IDLE.
- Beat counter width is max(1, clog2(BURST_LEN)).
- Events: ctrl_fire = ctrl_valid && ctrl_ready; out_fire = outs_valid && outs_ready; last = (cnt == BURST_LEN-1).
- ctrl_ready = (state==IDLE) || (out_fire && last). This is combinational from outs_ready; there is no path from ctrl_valid to ctrl_ready.
- IDLE:
  - On ctrl_fire: outs<=CONST_VALUE, cnt<=0, outs_valid<=1, go to EMIT.
  - Otherwise hold.
  - Latency is 1 cycle from ctrl_fire to outs_valid.
- EMIT, no out_fire: outs, cnt and outs_valid hold. Data must stay stable under backpressure.
- EMIT, out_fire with !last: cnt<=cnt+1, outs<=outs+STRIDE (mod 2^DATA_WIDTH).
- EMIT, out_fire with last and ctrl_valid (simultaneous end and new token):
  - Restart immediately: outs<=CONST_VALUE, cnt<=0, outs_valid stays 1, remain in EMIT.
  - No bubble, so BURST_LEN=1 sustains 1 token/cycle.
- EMIT, out_fire with last and !ctrl_valid: outs_valid<=0, cnt<=0, go to IDLE. outs holds its last value; it is don't-care but must not toggle.
- Arithmetic: outs adds with DATA_WIDTH-bit wrap and no saturation. Beat k value = CONST_VALUE + k*STRIDE mod 2^DATA_WIDTH.
- Control tokens never carry data and are never dropped or duplicated: exactly BURST_LEN out_fires per ctrl_fire.
- Reset mid-burst: the burst is abandoned, outs_valid drops asynchronously, and no partial burst resumes after reset.
- outs_valid never deasserts without out_fire (except on reset).

Optional Feature:
- Macro: HANDSHAKE_CONST_LAST_EN.
- Defined:
  - Adds the outs_last output port, registered and reset to 0.
  - outs_last=1 exactly when outs_valid=1 and cnt==BURST_LEN-1; it is updated alongside outs.
  - With BURST_LEN=1, outs_last equals outs_valid.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, release, ctrl_valid=0 -> outs_valid=0, outs=0, ctrl_ready=1 throughout.
2. Burst values: DATA_WIDTH=8, CONST_VALUE=0x10, STRIDE=3, BURST_LEN=4, outs_ready=1, one ctrl token.
   - outs = 0x10, 0x13, 0x16, 0x19 on consecutive cycles starting 1 cycle after ctrl_fire.
   - Then outs_valid=0; ctrl_ready=0 during beats 0-2 and 1 during beat 3.
   - outs_last=1 only on 0x19 when the macro is defined.
3. Wrap-around: DATA_WIDTH=8, CONST_VALUE=0xFE, STRIDE=1, BURST_LEN=3 -> outs = 0xFE, 0xFF, 0x00.
4. Backpressure: scenario 2 with outs_ready low for 5 cycles on beat 1 -> outs holds 0x13 with outs_valid=1 for all 5 cycles; no value skipped; total 4 beats.
5. Back-to-back throughput: BURST_LEN=1, STRIDE=0, CONST_VALUE=0xA5, ctrl_valid and outs_ready held 1 for 10 cycles -> 10 tokens of 0xA5 in 10 consecutive cycles after the first-cycle latency; equal ctrl_fire and out_fire counts.
6. Reset mid-operation: assert rst=0 asynchronously during beat 2 of scenario 2 -> outs_valid=0 and outs=0 immediately. After release with ctrl_valid=0, nothing is emitted; the next token restarts at 0x10.
